// File: rtl/alu.sv
// rtl/alu.sv - 8-bit registered ALU with 16 operations and a carry/borrow flag
// Result and flag are computed combinationally from A, B, F and the held Carry, then registered.
module alu (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       F0,
  input  logic       F1,
  input  logic       F2,
  input  logic       F3,
  output logic [7:0] Q,
  output logic       Carry
);

  logic [3:0] f;
  logic [8:0] sum_ab;
  logic [8:0] diff_ab;
  logic [8:0] inc_a;
  logic [8:0] dec_a;
  logic [8:0] adc_ab;
  logic [7:0] r_next;
  logic       c_next;

  assign f = {F3, F2, F1, F0};

  // Bit 8 of each 9-bit result is the carry out, or the borrow for the subtractions.
  assign sum_ab  = {1'b0, A} + {1'b0, B};
  assign diff_ab = {1'b0, A} - {1'b0, B};
  assign inc_a   = {1'b0, A} + 9'd1;
  assign dec_a   = {1'b0, A} - 9'd1;
  assign adc_ab  = sum_ab + {8'd0, Carry};

  always_comb begin
    r_next = 8'h00;
    c_next = 1'b0;
    case (f)
      4'b0000: r_next = ~A;
      4'b0001: r_next = ~B;
      4'b0010: r_next = A & B;
      4'b0011: r_next = A | B;
      4'b0100: r_next = A ^ B;
      4'b0101: r_next = ~(A & B);
      4'b0110: r_next = ~(A | B);
      4'b0111: r_next = ~(A ^ B);
      4'b1000: {c_next, r_next} = sum_ab;
      4'b1001: {c_next, r_next} = diff_ab;
      4'b1010: {c_next, r_next} = inc_a;
      4'b1011: {c_next, r_next} = dec_a;
      4'b1100: {c_next, r_next} = {A[7], A[6:0], 1'b0};
      4'b1101: {c_next, r_next} = {A[0], 1'b0, A[7:1]};
      4'b1110: {c_next, r_next} = {A[7], A[6:0], A[7]};
      4'b1111: {c_next, r_next} = adc_ab;
      default: begin
        r_next = 8'h00;
        c_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Q     <= 8'h00;
      Carry <= 1'b0;
    end else begin
      Q     <= r_next;
      Carry <= c_next;
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - self-checking bench for alu: arithmetic reference model plus directed literal vectors
module tb_alu;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] a, b;
  logic [3:0] f;
  logic [7:0] q;
  logic       carry;

  int errors = 0;
  int checks = 0;

  int exp_q = 0;
  int exp_c = 0;
  bit mvalid = 1'b0;

  alu dut (
    .clk(clk), .reset(reset), .A(a), .B(b),
    .F0(f[0]), .F1(f[1]), .F2(f[2]), .F3(f[3]),
    .Q(q), .Carry(carry)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on 0..255 values, result packed as carry*256 + result.
  function automatic int model(input int av, input int bv, input int fv, input int cin);
    int r, c, s;
    logic [7:0] la, lb;
    la = av[7:0];
    lb = bv[7:0];
    r = 0;
    c = 0;
    case (fv)
      0:  r = 255 - av;
      1:  r = 255 - bv;
      2:  r = int'(la & lb);
      3:  r = int'(la | lb);
      4:  r = int'(la ^ lb);
      5:  r = 255 - int'(la & lb);
      6:  r = 255 - int'(la | lb);
      7:  r = 255 - int'(la ^ lb);
      8:  begin s = av + bv; r = s % 256; c = (s >= 256) ? 1 : 0; end
      9:  begin r = (av - bv + 256) % 256; c = (av < bv) ? 1 : 0; end
      10: begin r = (av + 1) % 256; c = (av == 255) ? 1 : 0; end
      11: begin r = (av + 255) % 256; c = (av == 0) ? 1 : 0; end
      12: begin r = (av * 2) % 256; c = av / 128; end
      13: begin r = av / 2; c = av % 2; end
      14: begin r = (av * 2) % 256 + av / 128; c = av / 128; end
      default: begin s = av + bv + cin; r = s % 256; c = (s >= 256) ? 1 : 0; end
    endcase
    return c * 256 + r;
  endfunction

  always @(posedge clk) begin
    int m;
    if (reset) begin
      exp_q  <= 0;
      exp_c  <= 0;
      mvalid <= 1'b1;
    end else if (mvalid) begin
      m = model(int'(a), int'(b), int'(f), exp_c);
      exp_q <= m % 256;
      exp_c <= m / 256;
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      checks++;
      if (q !== exp_q[7:0] || carry !== exp_c[0]) begin
        errors++;
        $display("FAIL model t=%0t f=%b a=%h b=%h: Q=%h Carry=%b, required Q=%h Carry=%0d",
                 $time, f, a, b, q, carry, exp_q[7:0], exp_c);
      end
    end
  end

  task automatic step(input logic r, input logic [7:0] av, input logic [7:0] bv, input logic [3:0] fv);
    @(negedge clk);
    reset = r;
    a = av;
    b = bv;
    f = fv;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_lit(input string name, input logic [7:0] eq, input logic ec);
    checks++;
    if (q !== eq || carry !== ec) begin
      errors++;
      $display("FAIL %s: Q=%h Carry=%b, required Q=%h Carry=%b", name, q, carry, eq, ec);
    end
  endtask

  initial begin
    reset = 1'b1;
    a = 8'h55;
    b = 8'h00;
    f = 4'b1000;

    step(1'b1, 8'h55, 8'h00, 4'b1000); expect_lit("reset1", 8'h00, 1'b0);
    step(1'b1, 8'h55, 8'h00, 4'b1000); expect_lit("reset2", 8'h00, 1'b0);

    step(1'b0, 8'h00, 8'h00, 4'b0000); expect_lit("not_a_00", 8'hFF, 1'b0);
    step(1'b0, 8'hA5, 8'h00, 4'b0000); expect_lit("not_a_a5", 8'h5A, 1'b0);

    step(1'b0, 8'hFF, 8'h01, 4'b1000); expect_lit("add_ff_01", 8'h00, 1'b1);
    step(1'b0, 8'h10, 8'h20, 4'b1111); expect_lit("adc_cin1", 8'h31, 1'b0);

    step(1'b0, 8'h03, 8'h05, 4'b1001); expect_lit("sub_borrow", 8'hFE, 1'b1);
    step(1'b0, 8'h05, 8'h03, 4'b1001); expect_lit("sub_noborrow", 8'h02, 1'b0);

    step(1'b0, 8'h81, 8'h00, 4'b1100); expect_lit("shl_81", 8'h02, 1'b1);
    step(1'b0, 8'h81, 8'h00, 4'b1101); expect_lit("shr_81", 8'h40, 1'b1);
    step(1'b0, 8'h81, 8'h00, 4'b1110); expect_lit("rol_81", 8'h03, 1'b1);

    step(1'b0, 8'hFF, 8'h00, 4'b1010); expect_lit("inc_ff", 8'h00, 1'b1);
    step(1'b0, 8'h00, 8'h00, 4'b1011); expect_lit("dec_00", 8'hFF, 1'b1);
    step(1'b0, 8'hF0, 8'h3C, 4'b0101); expect_lit("nand", 8'hCF, 1'b0);
    step(1'b0, 8'hF0, 8'h3C, 4'b0111); expect_lit("xnor", 8'h33, 1'b0);
    step(1'b0, 8'hFF, 8'hFF, 4'b1111); expect_lit("adc_ff_ff_c0", 8'hFE, 1'b1);
    step(1'b0, 8'hFF, 8'hFF, 4'b1111); expect_lit("adc_ff_ff_c1", 8'hFF, 1'b1);

    step(1'b0, 8'hFF, 8'h01, 4'b1000); expect_lit("pre_reset_add", 8'h00, 1'b1);
    step(1'b1, 8'hFF, 8'h01, 4'b1000); expect_lit("midstream_reset", 8'h00, 1'b0);
    step(1'b0, 8'h01, 8'h01, 4'b1111); expect_lit("adc_after_reset", 8'h02, 1'b0);

    // Every op over a few boundary operand pairs; the model process checks each cycle.
    for (int p = 0; p < 4; p++) begin
      for (int op = 0; op < 16; op++) begin
        case (p)
          0: step(1'b0, 8'h00, 8'hFF, op[3:0]);
          1: step(1'b0, 8'hFF, 8'h00, op[3:0]);
          2: step(1'b0, 8'h80, 8'h7F, op[3:0]);
          default: step(1'b0, 8'h5A, 8'hC3, op[3:0]);
        endcase
      end
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
